// File: rtl/fle_pkg.sv
// Shared types and helpers for the parametrised CLB fracturable logic element.
package fle_pkg;

    typedef enum logic [1:0] {
        LUTK  = 2'b00,
        DUAL  = 2'b01,
        ARITH = 2'b10
    } fle_mode_e;

    typedef enum logic [1:0] {
        RUN,
        SHIFT,
        SETTLE
    } fle_state_e;

    // Config word: 2^k mask bits, 2 mode bits, 2 regsel bits.
    function automatic int fle_cfg_w(input int k);
        return (1 << k) + 4;
    endfunction

endpackage

// File: rtl/fle_if.sv
// Data and config-chain signals of one FLE. Optional FLE_CLK_ENABLE_EN adds fle_ce.
interface fle_if #(
    parameter int K = 4
);
    logic [K-1:0] fle_in;
    logic         fle_cin;
    logic         ccff_en;
    logic         ccff_head;
    logic [1:0]   fle_out;
    logic         fle_cout;
    logic         ccff_tail;
    logic         cfg_valid;

`ifdef FLE_CLK_ENABLE_EN
    logic         fle_ce;

    modport master (
        output fle_in, fle_cin, ccff_en, ccff_head, fle_ce,
        input  fle_out, fle_cout, ccff_tail, cfg_valid
    );

    modport slave (
        input  fle_in, fle_cin, ccff_en, ccff_head, fle_ce,
        output fle_out, fle_cout, ccff_tail, cfg_valid
    );
`else
    modport master (
        output fle_in, fle_cin, ccff_en, ccff_head,
        input  fle_out, fle_cout, ccff_tail, cfg_valid
    );

    modport slave (
        input  fle_in, fle_cin, ccff_en, ccff_head,
        output fle_out, fle_cout, ccff_tail, cfg_valid
    );
`endif

endinterface

// File: rtl/fle_lut_mux.sv
// 2^N:1 truth-table mux; one instance per half of the fractured LUT.
module fle_lut_mux #(
    parameter int N = 3
) (
    input  logic [(1<<N)-1:0] mask,
    input  logic [N-1:0]      sel,
    output logic              out
);

    assign out = mask[sel];

endmodule

// File: rtl/logical_tile_clb_fle_param.sv
// Fracturable logic element: K-LUT / dual (K-1)-LUT / adder slice with its own config chain.
// Optional macro FLE_CLK_ENABLE_EN gates user FF updates with fle_ce.
//
// state  | meaning
// RUN    | normal operation; outputs live when config is valid
// SHIFT  | config chain is shifting; outputs forced low
// SETTLE | one cycle after a load; user FFs cleared, outputs forced low
module logical_tile_clb_fle_param
    import fle_pkg::*;
#(
    parameter int K = 4
) (
    input  logic  fle_clk,
    input  logic  fle_reset,
    fle_if.slave  bus
);

    localparam int CFG_W  = fle_cfg_w(K);
    localparam int MASK_W = 1 << K;
    localparam int HALF   = 1 << (K - 1);
    localparam int CNT_W  = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CFG_W-1:0]  cfg;
    logic [CNT_W-1:0]  cnt;
    fle_state_e        state;
    logic              cfg_valid_q;
    logic [1:0]        ff;

    logic [MASK_W-1:0] mask;
    logic [1:0]        mode;
    logic [1:0]        regsel;
    logic              lo;
    logic              hi;
    logic [1:0]        c;
    logic              cout_c;
    logic              gate;
    logic              ff_upd;
    logic [1:0]        out_sel;

    assign mask   = cfg[MASK_W-1:0];
    assign mode   = cfg[MASK_W+1:MASK_W];
    assign regsel = cfg[MASK_W+3:MASK_W+2];

    fle_lut_mux #(.N(K - 1)) u_lut_lo (
        .mask (mask[HALF-1:0]),
        .sel  (bus.fle_in[K-2:0]),
        .out  (lo)
    );

    fle_lut_mux #(.N(K - 1)) u_lut_hi (
        .mask (mask[MASK_W-1:HALF]),
        .sel  (bus.fle_in[K-2:0]),
        .out  (hi)
    );

    always_comb begin
        c      = 2'b00;
        cout_c = 1'b0;
        case (mode)
            DUAL: begin
                c = {hi, lo};
            end
            ARITH: begin
                c      = {hi, lo ^ hi ^ bus.fle_cin};
                cout_c = (lo & hi) | (bus.fle_cin & (lo ^ hi));
            end
            // LUTK and the unused 2'b11 encoding both act as a full K-LUT
            default: begin
                c[0] = bus.fle_in[K-1] ? hi : lo;
            end
        endcase
    end

    assign gate = (state == RUN) && cfg_valid_q && !bus.ccff_en;

`ifdef FLE_CLK_ENABLE_EN
    assign ff_upd = gate && bus.fle_ce;
`else
    assign ff_upd = gate;
`endif

    assign out_sel[0] = regsel[0] ? ff[0] : c[0];
    assign out_sel[1] = regsel[1] ? ff[1] : c[1];

    assign bus.fle_out   = gate ? out_sel : 2'b00;
    assign bus.fle_cout  = gate & cout_c;
    assign bus.ccff_tail = cfg[CFG_W-1];
    assign bus.cfg_valid = cfg_valid_q;

    // Chain shifts on the user clock; first bit shifted in ends at the MSB.
    always_ff @(posedge fle_clk or posedge fle_reset) begin
        if (fle_reset) begin
            cfg <= '0;
        end else if (bus.ccff_en) begin
            cfg <= {cfg[CFG_W-2:0], bus.ccff_head};
        end
    end

    always_ff @(posedge fle_clk or posedge fle_reset) begin
        if (fle_reset) begin
            state       <= RUN;
            cnt         <= '0;
            cfg_valid_q <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (bus.ccff_en) begin
                        if (cnt != CNT_FULL) begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        state       <= SETTLE;
                        cfg_valid_q <= (cnt == CNT_FULL);
                    end
                end
                default: begin
                    if (bus.ccff_en) begin
                        state       <= SHIFT;
                        cnt         <= CNT_ONE;
                        cfg_valid_q <= 1'b0;
                    end else if (state == SETTLE) begin
                        state <= RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge fle_clk or posedge fle_reset) begin
        if (fle_reset) begin
            ff <= 2'b00;
        end else if (state == SETTLE) begin
            ff <= 2'b00;
        end else if (ff_upd) begin
            ff <= c;
        end
    end

endmodule

// File: tb/tb_logical_tile_clb_fle_param.sv
// Randomized bench for the FLE against a behavioural model of the config chain and logic.
module tb_logical_tile_clb_fle_param;

    localparam int K     = 4;
    localparam int CFG_W = 20;
    localparam int HALF  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fle_if #(.K(K)) bus ();

    logical_tile_clb_fle_param #(.K(K)) dut (
        .fle_clk   (clk),
        .fle_reset (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: history of shifted bits (newest at back), load bookkeeping, user FFs.
    bit       q[$];
    bit       in_burst;
    bit       settle;
    bit       valid_m;
    int       burst;
    bit [1:0] ff_m;
    bit       ce_m;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", tag, act, exp);
        end
    endtask

    // Bit i of the config word is the i-th most recently shifted bit.
    function automatic bit cfg_bit(input int i);
        if (i < q.size()) return q[q.size() - 1 - i];
        return 1'b0;
    endfunction

    task automatic eval(output bit g, output bit [1:0] c, output bit co);
        int idx;
        int mode;
        int sum;
        bit lo;
        bit hi;
        idx  = int'(bus.fle_in) % HALF;
        lo   = cfg_bit(idx);
        hi   = cfg_bit(HALF + idx);
        mode = 2 * int'(cfg_bit(17)) + int'(cfg_bit(16));
        sum  = int'(lo) + int'(hi) + int'(bus.fle_cin);
        g    = !in_burst && !settle && valid_m && !bus.ccff_en;
        co   = 1'b0;
        if (mode == 1) begin
            c = {hi, lo};
        end else if (mode == 2) begin
            c  = {hi, bit'(sum % 2)};
            co = (sum >= 2);
        end else begin
            c = {1'b0, bus.fle_in[3] ? hi : lo};
        end
    endtask

    task automatic drive(input bit en, input bit head, input bit [3:0] in, input bit cin, input bit ce);
        bit       g;
        bit [1:0] c;
        bit       co;
        bit [1:0] rs;
        bit [1:0] exp_out;
        bus.ccff_en   = en;
        bus.ccff_head = head;
        bus.fle_in    = in;
        bus.fle_cin   = cin;
        ce_m          = ce;
`ifdef FLE_CLK_ENABLE_EN
        bus.fle_ce    = ce;
`endif
        #3;
        eval(g, c, co);
        rs         = {cfg_bit(19), cfg_bit(18)};
        exp_out[0] = g & (rs[0] ? ff_m[0] : c[0]);
        exp_out[1] = g & (rs[1] ? ff_m[1] : c[1]);
        chk("fle_out", bus.fle_out, exp_out);
        chk("fle_cout", bus.fle_cout, g & co);
        chk("ccff_tail", bus.ccff_tail, (q.size() == CFG_W) ? q[0] : 1'b0);
        chk("cfg_valid", bus.cfg_valid, valid_m);
    endtask

    task automatic tick();
        bit       g;
        bit [1:0] c;
        bit       co;
        bit       ce_eff;
        eval(g, c, co);
`ifdef FLE_CLK_ENABLE_EN
        ce_eff = ce_m;
`else
        ce_eff = 1'b1;
`endif
        @(posedge clk);
        if (settle) ff_m = 2'b00;
        else if (g && ce_eff) ff_m = c;
        if (bus.ccff_en) begin
            q.push_back(bus.ccff_head);
            if (q.size() > CFG_W) void'(q.pop_front());
            if (!in_burst) begin
                in_burst = 1'b1;
                burst    = 1;
                valid_m  = 1'b0;
                settle   = 1'b0;
            end else begin
                burst++;
            end
        end else if (in_burst) begin
            in_burst = 1'b0;
            valid_m  = (burst >= CFG_W);
            settle   = 1'b1;
        end else begin
            settle = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.ccff_en = 1'b0;
        #1;
        q.delete();
        in_burst = 1'b0;
        settle   = 1'b0;
        valid_m  = 1'b0;
        burst    = 0;
        ff_m     = 2'b00;
        chk("rst_out", bus.fle_out, 2'b00);
        chk("rst_cout", bus.fle_cout, 1'b0);
        chk("rst_tail", bus.ccff_tail, 1'b0);
        chk("rst_valid", bus.cfg_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Sends bits[n-1] first; also checks the chain delay once the load exceeds CFG_W.
    task automatic load(input logic [63:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, bits[n-1-i], 4'($urandom), 1'($urandom), 1'($urandom));
            if (i >= CFG_W) chk("tail_order", bus.ccff_tail, bits[n-1-(i-CFG_W)]);
            tick();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 4'($urandom), 1'($urandom), 1'b1);
            tick();
        end
    endtask

    task automatic run_rand(input int n);
        for (int i = 0; i < n; i++) begin
            drive(($urandom_range(0, 15) == 0), 1'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom));
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [19:0] word;
        logic [63:0] bits;
        int          n;

        bus.ccff_en   = 1'b0;
        bus.ccff_head = 1'b0;
        bus.fle_in    = '0;
        bus.fle_cin   = 1'b0;
        ce_m          = 1'b1;
`ifdef FLE_CLK_ENABLE_EN
        bus.fle_ce    = 1'b1;
`endif
        #1;
        do_reset();

        // Reset part-way through a load
        load(64'hFFFFF, 10);
        do_reset();
        idle(2);
        chk("t1_valid", bus.cfg_valid, 1'b0);

        // AND4 in plain LUT mode
        load(64'h08000, 20);
        idle(2);
        drive(1'b0, 1'b0, 4'hF, 1'b0, 1'b1);
        chk("t2_valid", bus.cfg_valid, 1'b1);
        chk("t2_in_f", bus.fle_out, 2'b01);
        tick();
        drive(1'b0, 1'b0, 4'hE, 1'b0, 1'b1);
        chk("t2_in_e", bus.fle_out, 2'b00);
        tick();

        // One bit short never validates
        load(64'h08000 >> 1, 19);
        idle(2);
        chk("t3_valid", bus.cfg_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 4'($urandom), 1'($urandom), 1'b1);
            chk("t3_out", bus.fle_out, 2'b00);
            tick();
        end

        // Adder slice
        load(64'h2CCAA, 20);
        idle(2);
        drive(1'b0, 1'b0, 4'b0011, 1'b1, 1'b1);
        chk("t4_sum_c1", bus.fle_out[0], 1'b1);
        chk("t4_cout_c1", bus.fle_cout, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'b0011, 1'b0, 1'b1);
        chk("t4_sum_c0", bus.fle_out[0], 1'b0);
        chk("t4_cout_c0", bus.fle_cout, 1'b1);
        tick();

        // Registered output, cleared by SETTLE
        load(64'h48000, 20);
        drive(1'b0, 1'b0, 4'hF, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'hF, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("t5_first_run", bus.fle_out[0], 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'hF, 1'b0, 1'b1);
        chk("t5_before", bus.fle_out[0], 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'hF, 1'b0, 1'b1);
        chk("t5_after", bus.fle_out[0], 1'b1);
        tick();

        // Over-shift: last 20 bits win
        bits = {$urandom, $urandom};
        load(bits, 25);
        idle(2);
        chk("t6_valid", bus.cfg_valid, 1'b1);
        run_rand(4);

`ifdef FLE_CLK_ENABLE_EN
        // Dual mode, both outputs registered, lo=0F hi=F0
        load(64'hDF00F, 20);
        idle(2);
        drive(1'b0, 1'b0, 4'hA, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'h5, 1'b0, 1'b0);
        chk("ce_capture", bus.fle_out, 2'b01);
        tick();
        drive(1'b0, 1'b0, 4'h5, 1'b0, 1'b1);
        chk("ce_hold", bus.fle_out, 2'b01);
        tick();
        drive(1'b0, 1'b0, 4'h5, 1'b0, 1'b1);
        chk("ce_update", bus.fle_out, 2'b10);
        tick();
`endif

        repeat (40) begin
            word = 20'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                load(64'(word), $urandom_range(1, 15));
                do_reset();
            end else begin
                case ($urandom_range(0, 4))
                    0:       n = 19;
                    1:       n = 22;
                    default: n = 20;
                endcase
                bits = {$urandom, $urandom};
                if (n == 20) bits = 64'(word);
                load(bits, n);
                idle($urandom_range(1, 3));
                run_rand(8);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
